fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch and next-PC sequencer. It owns the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and presents each instruction to the datapath and decoder. It then consumes the decoder's jump/beq/bne outputs and the ALU zero flag to select the next PC. It is the consumer end of the control-unit branch/jump interface.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset; bit0 must be 0.
PC_STEP, 2, byte increment per sequential instruction.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request; held high until imem_ack.
imem_addr  out  16  fetch address; equals pc while imem_req is high.
imem_ack  in  1  memory accepted the request; imem_rdata is valid in the same cycle.
imem_rdata  in  16  instruction word.
instr  out  16  registered current instruction; opcode = instr[15:12].
instr_valid  out  1  instr is stable and is being executed.
exec_done  in  1  datapath finished the current instruction; control inputs are valid this cycle.
jump  in  1  from control unit.
beq  in  1  from control unit.
bne  in  1  from control unit.
alu_zero  in  1  ALU zero flag for the current instruction.
pc  out  16  address of the current instruction.
pc_plus2  out  16  pc + PC_STEP, combinational.

Behaviour:
- Reset (async): state=S_RESET, pc=RESET_PC, instr=16'h0000, imem_req=0, instr_valid=0.
- States: S_RESET, S_FETCH, S_ISSUE, S_UPDATE.
- S_RESET: unconditionally moves to S_FETCH on the first clk edge after reset deasserts.
- S_FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, go to S_ISSUE.
  - No timeout; req is held indefinitely.
- S_ISSUE: instr_valid=1.
  - Hold until exec_done=1.
  - In that cycle, register next_pc and go to S_UPDATE.
  - exec_done is ignored in all other states.
- S_UPDATE: pc<=next_pc, instr_valid=0, go to S_FETCH. Fetch of the next instruction starts the cycle after the update.
- Minimum latency per instruction: 3 cycles. Timeline with imem_ack in the first FETCH cycle and exec_done in the first ISSUE cycle: FETCH, ISSUE, UPDATE.
- next_pc priority:
  1. jump=1: {pc_plus2[15:13], instr[11:0], 1'b0}.
  2. Otherwise, branch taken when (beq & alu_zero) | (bne & ~alu_zero): pc_plus2 + {{9{instr[5]}}, instr[5:0], 1'b0}. This is a signed 6-bit word offset.
  3. Otherwise: pc_plus2.
- beq and bne both high is an illegal decoder output. The taken expression above still applies; the bench flags an assertion.
- All PC arithmetic is modulo 2^16; 16'hFFFE + 2 wraps to 16'h0000.
- imem_addr[0] is always 0. Computed targets are forced even by construction.
- Reserved opcodes (1010, 1111) get no special handling; they behave per control-unit outputs.
- Reset mid-fetch or mid-issue drops imem_req and instr_valid immediately (asynchronous). No partial PC update occurs.
- imem_ack outside S_FETCH is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding for S_RESET..S_UPDATE (2-bit);
  - opcode constants OP_LW=0, OP_SW=1, OP_BEQ=4'b1011, OP_BNE=4'b1100, OP_J=4'b1101;
  - PC_W=16 and INSTR_W=16.
- One natural sub-module, next_pc_calc: combinational target selection (jump/branch/sequential). It lets the target arithmetic be unit-tested separately from the FSM.

Test Plan:
1. Reset and sequential fetch: reset, then ack every fetch with opcode 0010 and exec_done immediate. Required: imem_addr = 0000, 0002, 0004, ...; each instruction takes 3 cycles.
2. Jump: pc=0x2004, instr=0xD123, jump=1 at exec_done. Required: next fetch address = {0x2006[15:13], 0x123, 0} = 0x2246.
3. Branches: BEQ at pc=0x0010 with offset 6'h3E (-2) and alu_zero=1 gives next 0x000E. BEQ with alu_zero=0 gives 0x0012. BNE with alu_zero=0 and offset 6'h04 gives 0x001A.
4. Handshake stalls: delay imem_ack 5 cycles, then hold exec_done low 4 cycles. Required: imem_req and imem_addr stable throughout the fetch wait; instr_valid stays high and instr stays stable throughout the issue wait; pc changes only in S_UPDATE.
5. Wrap-around: RESET_PC=16'hFFFE with sequential execution. Required: second fetch at 16'h0000.
6. Async reset mid-operation: assert reset between clk edges during S_ISSUE with pc=0x0040. Required: instr_valid=0 and pc=RESET_PC immediately, before the next edge. After release, the first fetch goes to RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch-sequencer state encoding and
// the opcode values the decoder produces.
package cpu_pkg;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_UPDATE = 2'd3
    } state_t;

    localparam logic [3:0] OP_LW  = 4'b0000;
    localparam logic [3:0] OP_SW  = 4'b0001;
    localparam logic [3:0] OP_BEQ = 4'b1011;
    localparam logic [3:0] OP_BNE = 4'b1100;
    localparam logic [3:0] OP_J   = 4'b1101;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, PC-relative branch, or the
// sequential successor, in that priority order.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [PC_W-1:0] pc_plus2,
    input  logic [11:0]     target,
    input  logic            jump,
    input  logic            beq,
    input  logic            bne,
    input  logic            alu_zero,
    output logic [PC_W-1:0] next_pc
);

    // Signed word offset scaled to bytes; bit0 is zero so targets stay even.
    function automatic logic signed [PC_W-1:0] branch_offset(input logic [5:0] words);
        return {{(PC_W-7){words[5]}}, words, 1'b0};
    endfunction

    logic taken;

    always_comb begin
        taken   = (beq & alu_zero) | (bne & ~alu_zero);
        next_pc = pc_plus2;
        if (jump) begin
            next_pc = {pc_plus2[PC_W-1:13], target, 1'b0};
        end else if (taken) begin
            next_pc = pc_plus2 + $unsigned(branch_offset(target[5:0]));
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / next-PC sequencer: fetches over req/ack, holds the
// instruction while the datapath executes it, then commits the next PC.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_STEP  = 16'd2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               jump,
    input  logic               beq,
    input  logic               bne,
    input  logic               alu_zero,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus2
);

    state_t          state;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] npc_p0;

    assign pc_plus2  = pc + PC_STEP;
    assign imem_addr = pc;

    next_pc_calc u_next_pc (
        .pc_plus2 (pc_plus2),
        .target   (instr[11:0]),
        .jump     (jump),
        .beq      (beq),
        .bne      (bne),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_RESET;
            pc          <= RESET_PC;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (exec_done) begin
                        instr_valid <= 1'b0;
                        state       <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    pc       <= npc_p0;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    state       <= S_RESET;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Issue -> update boundary: target captured while the control inputs are valid.
    always_ff @(posedge clk) begin
        if (state == S_ISSUE && exec_done) begin
            npc_p0 <= next_pc;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// instruction streams checked against an arithmetic next-PC reference model.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, instr_valid;
    logic [15:0] imem_addr, instr, pc, pc_plus2;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        exec_done = 1'b0, jump = 1'b0, beq = 1'b0, bne = 1'b0, alu_zero = 1'b0;

    logic        w_req, w_valid;
    logic [15:0] w_addr, w_instr, w_pc, w_pc_plus2;
    logic        w_ack = 1'b0, w_exec = 1'b0;
    logic [15:0] w_rdata = 16'h2000;
    logic        w_ctl = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_sequencer #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .exec_done(exec_done), .jump(jump), .beq(beq),
        .bne(bne), .alu_zero(alu_zero), .pc(pc), .pc_plus2(pc_plus2)
    );

    fetch_sequencer #(.RESET_PC(16'hFFFE), .PC_STEP(16'd2)) dut_w (
        .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .instr(w_instr),
        .instr_valid(w_valid), .exec_done(w_exec), .jump(w_ctl), .beq(w_ctl),
        .bne(w_ctl), .alu_zero(w_ctl), .pc(w_pc), .pc_plus2(w_pc_plus2)
    );

    always @(posedge clk) begin
        assert (!(instr_valid && exec_done && beq && bne))
            else $error("illegal decoder output: beq and bne both high");
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_next(input logic [15:0] pcv, input logic [15:0] w,
                                               input logic j, input logic b, input logic n,
                                               input logic z);
        int p2, off;
        p2 = (int'(pcv) + 2) % 65536;
        if (j) return 16'((p2 / 8192) * 8192 + (int'(w) % 4096) * 2);
        if ((b && z) || (n && !z)) begin
            off = int'(w) % 64;
            if (off >= 32) off = off - 64;
            return 16'((p2 + 2 * off + 65536) % 65536);
        end
        return 16'(p2);
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs one instruction through fetch and issue; returns at the UPDATE-cycle negedge.
    task automatic do_instr(input logic [15:0] word, input int ack_dly, input int exec_dly,
                            input logic j, input logic b, input logic n, input logic z,
                            output logic [15:0] addr, output int start_cyc, output bit timeout);
        int k;
        k = 0;
        addr = '0;
        start_cyc = 0;
        timeout = 1'b0;
        while (!imem_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!imem_req) begin
            timeout = 1'b1;
        end else begin
            addr = imem_addr;
            start_cyc = cyc;
            repeat (ack_dly) @(negedge clk);
            imem_ack = 1'b1;
            imem_rdata = word;
            @(negedge clk);
            imem_ack = 1'b0;
            repeat (exec_dly) begin
                imem_ack = 1'($urandom % 2);
                imem_rdata = 16'($urandom);
                @(negedge clk);
            end
            imem_ack = 1'b0;
            exec_done = 1'b1; jump = j; beq = b; bne = n; alu_zero = z;
            @(negedge clk);
            exec_done = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0000 || instr !== 16'h0000) begin
            fails++;
            $display("FAIL reset_state: req=%b valid=%b pc=%h instr=%h required 0 0 0000 0000",
                     imem_req, instr_valid, pc, instr);
        end
        tests++;
        if (w_pc !== 16'hFFFE || w_req !== 1'b0) begin
            fails++;
            $display("FAIL reset_pc_param: pc=%h req=%b required fffe 0", w_pc, w_req);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_first_fetch: req=%b addr=%h valid=%b required 1 0000 0",
                     imem_req, imem_addr, instr_valid);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] addr;
        int st, prev_st;
        bit to;
        prev_st = 0;
        for (int i = 0; i < 6; i++) begin
            do_instr({4'b0010, 12'($urandom)}, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, addr, st, to);
            tests++;
            if (to || addr !== 16'(2 * i)) begin
                fails++;
                $display("FAIL seq_addr[%0d]: got %h (timeout=%0b) required %h", i, addr, to, 16'(2 * i));
            end
            if (i > 0) begin
                tests++;
                if (st - prev_st != 3) begin
                    fails++;
                    $display("FAIL seq_latency[%0d]: got %0d cycles required 3", i, st - prev_st);
                end
            end
            prev_st = st;
        end
    endtask

    task automatic test_jump();
        logic [15:0] addr;
        int st;
        bit to;
        apply_reset();
        do_instr(16'hDFFF, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, addr, st, to);
        for (int i = 0; i < 3; i++)
            do_instr(16'h2000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, addr, st, to);
        do_instr(16'hD123, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, addr, st, to);
        tests++;
        if (to || addr !== 16'h2004) begin
            fails++;
            $display("FAIL jump_setup_pc: got %h required 2004", addr);
        end
        do_instr(16'h2000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, addr, st, to);
        tests++;
        if (to || addr !== 16'h2246) begin
            fails++;
            $display("FAIL jump_target: got %h required 2246", addr);
        end
    endtask

    task automatic test_branch();
        logic [15:0] addr;
        int st;
        bit to;
        apply_reset();
        do_instr(16'hD008, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, addr, st, to);
        do_instr(16'hB03E, 0, 1, 1'b0, 1'b1, 1'b0, 1'b1, addr, st, to);
        tests++;
        if (to || addr !== 16'h0010) begin
            fails++;
            $display("FAIL beq_setup_pc: got %h required 0010", addr);
        end
        do_instr(16'h2000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, addr, st, to);
        tests++;
        if (to || addr !== 16'h000E) begin
            fails++;
            $display("FAIL beq_taken: got %h required 000e", addr);
        end
        do_instr(16'hB03E, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, addr, st, to);
        do_instr(16'hB03E, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, addr, st, to);
        tests++;
        if (to || addr !== 16'h0012) begin
            fails++;
            $display("FAIL beq_not_taken: got %h required 0012", addr);
        end
        do_instr(16'hC004, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, addr, st, to);
        tests++;
        if (to || addr !== 16'h0010) begin
            fails++;
            $display("FAIL beq_back_to_0010: got %h required 0010", addr);
        end
        do_instr(16'h2000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, addr, st, to);
        tests++;
        if (to || addr !== 16'h001A) begin
            fails++;
            $display("FAIL bne_taken: got %h required 001a", addr);
        end
    endtask

    task automatic test_stall();
        logic [15:0] a0, word;
        int k;
        apply_reset();
        k = 0;
        while (!imem_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        a0 = imem_addr;
        word = 16'h2ABC;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (imem_req !== 1'b1 || imem_addr !== a0 || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL stall_fetch[%0d]: req=%b addr=%h valid=%b required 1 %h 0",
                         i, imem_req, imem_addr, instr_valid, a0);
            end
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        jump = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (instr_valid !== 1'b1 || instr !== word || pc !== a0 || imem_req !== 1'b0) begin
                fails++;
                $display("FAIL stall_issue[%0d]: valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
                         i, instr_valid, instr, pc, imem_req, word, a0);
            end
            @(negedge clk);
        end
        jump = 1'b0;
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        tests++;
        if (instr_valid !== 1'b0 || pc !== a0 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL stall_update: valid=%b pc=%h req=%b required 0 %h 0", instr_valid, pc, imem_req, a0);
        end
        @(negedge clk);
        tests++;
        if (pc !== a0 + 16'd2 || imem_req !== 1'b1) begin
            fails++;
            $display("FAIL stall_next_fetch: pc=%h req=%b required %h 1", pc, imem_req, a0 + 16'd2);
        end
    endtask

    task automatic test_wrap();
        int k;
        apply_reset();
        k = 0;
        while (!w_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (w_req !== 1'b1 || w_addr !== 16'hFFFE || w_pc_plus2 !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_first: req=%b addr=%h pc_plus2=%h required 1 fffe 0000", w_req, w_addr, w_pc_plus2);
        end
        w_ack = 1'b1;
        @(negedge clk);
        w_ack = 1'b0;
        w_exec = 1'b1;
        @(negedge clk);
        w_exec = 1'b0;
        k = 0;
        while (!w_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (w_req !== 1'b1 || w_addr !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_second: req=%b addr=%h required 1 0000", w_req, w_addr);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] addr;
        int st, k;
        bit to;
        apply_reset();
        do_instr(16'hD020, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, addr, st, to);
        k = 0;
        while (!imem_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        imem_ack = 1'b1;
        imem_rdata = 16'h2000;
        @(negedge clk);
        imem_ack = 1'b0;
        tests++;
        if (instr_valid !== 1'b1 || pc !== 16'h0040) begin
            fails++;
            $display("FAIL areset_setup: valid=%b pc=%h required 1 0040", instr_valid, pc);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (instr_valid !== 1'b0 || pc !== 16'h0000 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL areset_immediate: valid=%b pc=%h req=%b required 0 0000 0", instr_valid, pc, imem_req);
        end
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        while (!imem_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            fails++;
            $display("FAIL areset_refetch: req=%b addr=%h required 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        logic [15:0] addr, exp, word;
        logic j, b, n, z;
        int st, kind;
        bit to;
        apply_reset();
        exp = 16'h0000;
        for (int i = 0; i < 40; i++) begin
            word = 16'($urandom);
            j = ($urandom % 4 == 0);
            kind = $urandom % 3;
            b = (kind == 1);
            n = (kind == 2);
            z = 1'($urandom % 2);
            do_instr(word, $urandom_range(0, 3), $urandom_range(0, 3), j, b, n, z, addr, st, to);
            tests++;
            if (to || addr !== exp) begin
                fails++;
                $display("FAIL rand_addr[%0d]: got %h (timeout=%0b) required %h", i, addr, to, exp);
            end
            tests++;
            if (instr !== word) begin
                fails++;
                $display("FAIL rand_instr[%0d]: got %h required %h", i, instr, word);
            end
            exp = model_next(exp, word, j, b, n, z);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
